// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit between the program counter and instruction memory.
//   Strobes the PC (pc_e), reads the settled PC (pc_in), fetches the word at
//   that address over a req/ack handshake, and queues {address, word} in a
//   small in-order buffer that decode drains with valid/ready. A jump flush
//   discards buffered and in-flight words, then issues the strobe that loads
//   the jump target (pc_e together with flush_ack).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   pc_in               current PC value
//   pc_e                PC advance strobe (registered, single-cycle pulse)
//   flush, flush_ack    jump request level / target-load acknowledge pulse
//   imem_req/addr       memory read request and registered address
//   imem_ack/rdata      memory read completion and data
//   ir_valid/data/pc    oldest buffered word and its address
//   ir_ready            decode accepts the oldest word
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_e,
  input  logic              flush,
  output logic              flush_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready
);

  // state  | meaning
  // SETTLE | strobes low, pc_in settling after a strobe or reset
  // HOLD   | buffer full, waiting for decode to pop
  // REQ    | memory request outstanding, push on ack
  // STEP   | pc_e pulse advancing the PC
  // DRAIN  | flush arrived mid-request, wait for ack and drop the data
  // JSTEP  | pc_e + flush_ack pulse loading the jump target

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {SETTLE, HOLD, REQ, STEP, DRAIN, JSTEP} state_t;

  state_t            state_q, state_d;
  logic              pc_e_q, pc_e_d;
  logic              flush_ack_q, flush_ack_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [DATA_W-1:0] buf_data_d [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [DEPTH];
  logic [ADDR_W-1:0] buf_pc_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic has_space, push, pop;

  always_comb begin
    has_space = (count_q < FULL_CNT);
    state_d   = state_q;
    case (state_q)
      SETTLE: state_d = flush ? JSTEP : (has_space ? REQ : HOLD);
      HOLD: begin
        if (flush)          state_d = JSTEP;
        else if (has_space) state_d = REQ;
      end
      REQ: begin
        if (flush)         state_d = imem_ack ? JSTEP : DRAIN;
        else if (imem_ack) state_d = STEP;
      end
      STEP:    state_d = flush ? JSTEP : SETTLE;
      DRAIN:   if (imem_ack) state_d = JSTEP;
      JSTEP:   state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    // Outputs are decoded from the next state so they are flop outputs.
    pc_e_d      = (state_d == STEP) || (state_d == JSTEP);
    flush_ack_d = (state_d == JSTEP);
    imem_req_d  = (state_d == REQ) || (state_d == DRAIN);
    imem_addr_d = ((state_d == REQ) && (state_q != REQ)) ? pc_in : imem_addr_q;
  end

  // Flush wins over any push or pop in the same cycle.
  assign push = (state_q == REQ) && imem_ack && !flush;
  assign pop  = (count_q != '0) && ir_ready && !flush;

  always_comb begin
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_data_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]   = imem_addr_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SETTLE;
      pc_e_q      <= 1'b0;
      flush_ack_q <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_e_q      <= pc_e_d;
      flush_ack_q <= flush_ack_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      buf_data_q  <= buf_data_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign pc_e      = pc_e_q;
  assign flush_ack = flush_ack_q;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ir_valid  = (count_q != '0);
  assign ir_data   = buf_data_q[rd_ptr_q];
  assign ir_pc     = buf_pc_q[rd_ptr_q];

endmodule
